audio_dac_serializer: RTL and testbench

Streams mono PCM samples from the pitch generation stage to the audio codec DAC in I2S format, with the codec acting as bit-clock and LR-clock master. It sits directly downstream of the pitch generation block: it accepts samples over an Avalon-ST sink and drives the `dacdat` pin from the codec's `bclk`/`daclrck`. A one-entry buffer decouples the sample producer from the codec frame timing. The same sample is sent on both the left and right channels.

---
 rtl/audio_dac_serializer.sv | 187 ++++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer
// Takes mono PCM samples over an Avalon-ST sink, keeps one of them in a
// single-entry buffer, and shifts the current frame word out in I2S format
// on dacdat using the codec-mastered bclk/daclrck. The same word is sent on
// the left and right slots; a new word is only taken at each left-slot start.

module audio_dac_serializer #(
    parameter int DATA_W = 16
) (
    input  logic              csi_clk,
    input  logic              rsi_reset_n,
    input  logic [DATA_W-1:0] asi_data,
    input  logic              asi_valid,
    output logic              asi_ready,
    input  logic              coe_bclk,
    input  logic              coe_daclrck,
    output logic              coe_dacdat,
    output logic              coe_underrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SHIFT,
        PAD
    } state_t;

    state_t state;
    state_t state_next;

    logic bclk_meta;
    logic bclk_sync;
    logic bclk_hist;
    logic lr_meta;
    logic lr_sync;
    logic lr_hist;

    logic bclk_fall;
    logic lr_fall;
    logic lr_rise;
    logic lr_edge;

    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic [DATA_W-1:0] frame_data;
    logic              accept;
    logic              load_frame;

    logic [CNT_W-1:0] bitcnt;
    logic [CNT_W-1:0] bitcnt_dec;
    logic [CNT_W-1:0] bitcnt_next;
    logic             dacdat_next;

    // Bring the codec clocks into csi_clk with two flops, plus a history flop for edge detection.
    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            bclk_meta <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_hist <= 1'b0;
            lr_meta   <= 1'b0;
            lr_sync   <= 1'b0;
            lr_hist   <= 1'b0;
        end else begin
            bclk_meta <= coe_bclk;
            bclk_sync <= bclk_meta;
            bclk_hist <= bclk_sync;
            lr_meta   <= coe_daclrck;
            lr_sync   <= lr_meta;
            lr_hist   <= lr_sync;
        end
    end

    assign bclk_fall  = ~bclk_sync & bclk_hist;
    assign lr_fall    = ~lr_sync & lr_hist;
    assign lr_rise    = lr_sync & ~lr_hist;
    assign lr_edge    = lr_fall | lr_rise;

    assign asi_ready  = ~buf_full;
    assign accept     = asi_valid & ~buf_full;
    assign load_frame = lr_fall & buf_full;
    assign bitcnt_dec = bitcnt - 1'b1;

    // Buffer, frame word, bit counter, serial output and underrun pulse.
    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            buf_data     <= '0;
            buf_full     <= 1'b0;
            frame_data   <= '0;
            bitcnt       <= '0;
            coe_dacdat   <= 1'b0;
            coe_underrun <= 1'b0;
        end else begin
            if (accept) begin
                buf_data <= asi_data;
                buf_full <= 1'b1;
            end else if (load_frame) begin
                buf_full <= 1'b0;
            end
            if (load_frame) begin
                frame_data <= buf_data;
            end
            bitcnt       <= bitcnt_next;
            coe_dacdat   <= dacdat_next;
            coe_underrun <= lr_fall & ~buf_full;
        end
    end

    // State register.
    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: an LR edge always restarts the slot, otherwise bclk falls walk the word.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (lr_fall) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (lr_edge) begin
                    state_next = ARM;
                end else if (bclk_fall) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (lr_edge) begin
                    state_next = ARM;
                end else if (bclk_fall && (bitcnt == '0)) begin
                    state_next = PAD;
                end
            end
            PAD: begin
                if (lr_edge) begin
                    state_next = ARM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Serial data and bit index for the next cycle; a bclk fall in the LR-edge cycle is ignored.
    always_comb begin
        dacdat_next = 1'b0;
        bitcnt_next = bitcnt;
        case (state)
            IDLE: begin
                dacdat_next = 1'b0;
            end
            ARM: begin
                if (!lr_edge && bclk_fall) begin
                    dacdat_next = frame_data[MSB_IDX];
                    bitcnt_next = MSB_IDX;
                end
            end
            SHIFT: begin
                if (lr_edge) begin
                    dacdat_next = 1'b0;
                end else if (bclk_fall) begin
                    if (bitcnt == '0) begin
                        dacdat_next = 1'b0;
                    end else begin
                        dacdat_next = frame_data[bitcnt_dec];
                        bitcnt_next = bitcnt_dec;
                    end
                end else begin
                    dacdat_next = coe_dacdat;
                end
            end
            PAD: begin
                dacdat_next = 1'b0;
            end
            default: dacdat_next = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer
// Directed bench: the bench plays the codec (bclk = clk/16, LR toggling on a
// bclk falling edge) and samples dacdat just before each bclk rising edge.

module tb_audio_dac_serializer;

    localparam int DATA_W    = 16;
    localparam int HALF_BCLK = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] asi_data;
    logic              asi_valid;
    logic              asi_ready;
    logic              bclk;
    logic              lrck;
    logic              dacdat;
    logic              underrun;

    int checks = 0;
    int errors = 0;
    int underrun_cnt = 0;

    audio_dac_serializer #(.DATA_W(DATA_W)) dut (
        .csi_clk      (clk),
        .rsi_reset_n  (rst_n),
        .asi_data     (asi_data),
        .asi_valid    (asi_valid),
        .asi_ready    (asi_ready),
        .coe_bclk     (bclk),
        .coe_daclrck  (lrck),
        .coe_dacdat   (dacdat),
        .coe_underrun (underrun)
    );

    // 50 MHz system clock.
    always #10 clk = ~clk;

    // Count underrun pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (underrun === 1'b1) underrun_cnt++;
    end

    // Hard stop in case something never returns.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Expected slot: bit i is what dacdat shows at bclk rise i of a slot of nb bclks.
    function automatic logic [31:0] slot_expect(input logic [15:0] w, input int nb);
        logic [31:0] e;
        e = '0;
        for (int i = 1; i <= 16; i++) begin
            if (i < nb) e[i] = w[16-i];
        end
        return e;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bclk_bit(output logic b);
        bclk = 1'b0;
        wait_clks(HALF_BCLK);
        b = dacdat;
        bclk = 1'b1;
        wait_clks(HALF_BCLK);
    endtask

    task automatic run_slot(input logic lr, input int nb, output logic [31:0] bits);
        logic b;
        bits = '0;
        lrck = lr;
        for (int i = 0; i < nb; i++) begin
            bclk_bit(b);
            bits[i] = b;
        end
    endtask

    task automatic push_sample(input logic [15:0] d, output bit ok);
        ok = 1'b0;
        asi_data  = d;
        asi_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (asi_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        asi_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] bits;
        rst_n = 1'b0;
        bclk = 1'b1;
        lrck = 1'b1;
        asi_valid = 1'b1;
        asi_data = 16'hDEAD;
        wait_clks(4);
        checks++;
        if (dacdat !== 1'b0) begin errors++; $display("[TB] FAIL reset_dacdat: got %b expected 0", dacdat); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
        asi_valid = 1'b0;
        rst_n = 1'b1;
        wait_clks(1);
        checks++;
        if (asi_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", asi_ready); end
        wait_clks(4);
        run_slot(1'b1, 4, bits);
        checks++;
        if (bits !== 32'h0) begin errors++; $display("[TB] FAIL idle_output: got %h expected %h", bits, 32'h0); end
    endtask

    task automatic test_basic_left();
        logic [31:0] bits;
        bit ok;
        int u0;
        u0 = underrun_cnt;
        push_sample(16'hA5C3, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL basic_push: got no accept expected accept"); end
        run_slot(1'b0, 32, bits);
        checks++;
        if (bits !== 32'h0001_874A) begin errors++; $display("[TB] FAIL basic_left: got %h expected %h", bits, 32'h0001_874A); end
        checks++;
        if (asi_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_after_load: got %b expected 1", asi_ready); end
        run_slot(1'b1, 32, bits);
        checks++;
        if (bits !== 32'h0001_874A) begin errors++; $display("[TB] FAIL basic_right: got %h expected %h", bits, 32'h0001_874A); end
        checks++;
        if (underrun_cnt - u0 !== 0) begin errors++; $display("[TB] FAIL basic_underrun: got %0d expected 0", underrun_cnt - u0); end
    endtask

    task automatic test_underrun();
        logic [31:0] bits;
        logic [31:0] exp;
        bit ok;
        int u0;
        u0 = underrun_cnt;
        exp = slot_expect(16'h7FFF, 32);
        push_sample(16'h7FFF, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL underrun_push: got no accept expected accept"); end
        run_slot(1'b0, 32, bits);
        run_slot(1'b1, 32, bits);
        checks++;
        if (underrun_cnt - u0 !== 0) begin errors++; $display("[TB] FAIL underrun_first_frame: got %0d expected 0", underrun_cnt - u0); end
        run_slot(1'b0, 32, bits);
        checks++;
        if (bits !== exp) begin errors++; $display("[TB] FAIL underrun_repeat_left: got %h expected %h", bits, exp); end
        checks++;
        if (underrun_cnt - u0 !== 1) begin errors++; $display("[TB] FAIL underrun_pulse_1: got %0d expected 1", underrun_cnt - u0); end
        run_slot(1'b1, 32, bits);
        checks++;
        if (underrun_cnt - u0 !== 1) begin errors++; $display("[TB] FAIL underrun_right_no_pulse: got %0d expected 1", underrun_cnt - u0); end
        run_slot(1'b0, 32, bits);
        run_slot(1'b1, 32, bits);
        checks++;
        if (underrun_cnt - u0 !== 2) begin errors++; $display("[TB] FAIL underrun_pulse_2: got %0d expected 2", underrun_cnt - u0); end
    endtask

    task automatic test_backpressure();
        logic [31:0] lbits [3];
        logic [31:0] rbits;
        logic [31:0] exp;
        bit ok0, ok1, ok2;
        logic ready_after_first;
        int u0;
        u0 = underrun_cnt;
        ready_after_first = 1'bx;
        fork
            begin
                push_sample(16'h0001, ok0);
                ready_after_first = asi_ready;
                push_sample(16'h0002, ok1);
                push_sample(16'h0003, ok2);
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    run_slot(1'b0, 32, lbits[f]);
                    run_slot(1'b1, 32, rbits);
                end
            end
        join
        checks++;
        if (ready_after_first !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b expected 0", ready_after_first); end
        checks++;
        if ({ok0, ok1, ok2} !== 3'b111) begin errors++; $display("[TB] FAIL bp_accepts: got %b expected 111", {ok0, ok1, ok2}); end
        for (int f = 0; f < 3; f++) begin
            exp = slot_expect(16'(f + 1), 32);
            checks++;
            if (lbits[f] !== exp) begin errors++; $display("[TB] FAIL bp_frame_%0d: got %h expected %h", f, lbits[f], exp); end
        end
        checks++;
        if (underrun_cnt - u0 !== 0) begin errors++; $display("[TB] FAIL bp_underrun: got %0d expected 0", underrun_cnt - u0); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] bits;
        logic [31:0] exp;
        logic ready_at_offer;
        logic ready_after_offer;
        int u0;
        u0 = underrun_cnt;
        ready_at_offer = 1'bx;
        ready_after_offer = 1'bx;
        fork
            run_slot(1'b0, 32, bits);
            begin
                wait_clks(2);
                asi_data = 16'h1234;
                asi_valid = 1'b1;
                ready_at_offer = asi_ready;
                wait_clks(1);
                asi_valid = 1'b0;
                ready_after_offer = asi_ready;
            end
        join
        exp = slot_expect(16'h0003, 32);
        checks++;
        if (bits !== exp) begin errors++; $display("[TB] FAIL simul_old_frame: got %h expected %h", bits, exp); end
        checks++;
        if (underrun_cnt - u0 !== 1) begin errors++; $display("[TB] FAIL simul_underrun: got %0d expected 1", underrun_cnt - u0); end
        checks++;
        if ({ready_at_offer, ready_after_offer} !== 2'b10) begin errors++; $display("[TB] FAIL simul_accept: got %b expected 10", {ready_at_offer, ready_after_offer}); end
        run_slot(1'b1, 32, bits);
        run_slot(1'b0, 32, bits);
        exp = slot_expect(16'h1234, 32);
        checks++;
        if (bits !== exp) begin errors++; $display("[TB] FAIL simul_next_frame: got %h expected %h", bits, exp); end
        checks++;
        if (underrun_cnt - u0 !== 1) begin errors++; $display("[TB] FAIL simul_underrun_total: got %0d expected 1", underrun_cnt - u0); end
        run_slot(1'b1, 32, bits);
    endtask

    task automatic test_coincident();
        logic [31:0] bits;
        logic [31:0] exp;
        bit ok;
        push_sample(16'h8001, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL coinc_push: got no accept expected accept"); end
        run_slot(1'b0, 32, bits);
        checks++;
        if (bits[1:0] !== 2'b10) begin errors++; $display("[TB] FAIL coinc_msb_delay: got %b expected 10", bits[1:0]); end
        exp = slot_expect(16'h8001, 32);
        checks++;
        if (bits !== exp) begin errors++; $display("[TB] FAIL coinc_word: got %h expected %h", bits, exp); end
        run_slot(1'b1, 32, bits);
    endtask

    task automatic test_short_slot();
        logic [31:0] bits;
        logic [31:0] exp;
        bit ok;
        push_sample(16'hF0A5, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL short_push: got no accept expected accept"); end
        run_slot(1'b0, 8, bits);
        checks++;
        if (bits !== 32'h0000_001E) begin errors++; $display("[TB] FAIL short_left: got %h expected %h", bits, 32'h0000_001E); end
        run_slot(1'b1, 8, bits);
        checks++;
        if (bits !== 32'h0000_001E) begin errors++; $display("[TB] FAIL short_right: got %h expected %h", bits, 32'h0000_001E); end
        push_sample(16'h0F0F, ok);
        run_slot(1'b0, 32, bits);
        exp = slot_expect(16'h0F0F, 32);
        checks++;
        if (bits !== exp) begin errors++; $display("[TB] FAIL short_recover: got %h expected %h", bits, exp); end
        run_slot(1'b1, 8, bits);
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] bits;
        logic [31:0] exp;
        bit ok;
        int u0;
        push_sample(16'hFFFF, ok);
        run_slot(1'b0, 5, bits);
        checks++;
        if (dacdat !== 1'b1) begin errors++; $display("[TB] FAIL midword_shifting: got %b expected 1", dacdat); end
        push_sample(16'h5555, ok);
        rst_n = 1'b0;
        wait_clks(1);
        checks++;
        if (dacdat !== 1'b0) begin errors++; $display("[TB] FAIL midword_reset_dacdat: got %b expected 0", dacdat); end
        wait_clks(1);
        rst_n = 1'b1;
        wait_clks(1);
        checks++;
        if (asi_ready !== 1'b1) begin errors++; $display("[TB] FAIL midword_ready: got %b expected 1", asi_ready); end
        u0 = underrun_cnt;
        run_slot(1'b0, 8, bits);
        run_slot(1'b1, 32, bits);
        checks++;
        if (bits !== 32'h0) begin errors++; $display("[TB] FAIL midword_idle_zero: got %h expected %h", bits, 32'h0); end
        push_sample(16'h3C3C, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL midword_push: got no accept expected accept"); end
        run_slot(1'b0, 32, bits);
        exp = slot_expect(16'h3C3C, 32);
        checks++;
        if (bits !== exp) begin errors++; $display("[TB] FAIL midword_restart: got %h expected %h", bits, exp); end
        checks++;
        if (underrun_cnt - u0 !== 0) begin errors++; $display("[TB] FAIL midword_underrun: got %0d expected 0", underrun_cnt - u0); end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_basic_left();
        test_underrun();
        test_backpressure();
        test_simultaneous();
        test_coincident();
        test_short_slot();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
